ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage in-order LoongArch32 pipeline, directly feeding the MEM stage.
//  - Performs ALU, single-cycle multiply and iterative divide.
//  - Issues the data SRAM request, one cycle before MEM consumes data_sram_rdata.
//  - Produces the EX->MEM bundle: EX_rf_bus, EX_pc, EX_mem_ld_inst.
//  - Holds the pipeline with the valid/allowin handshake while a divide is in flight.
// PARAMETERS
//  DIV_ITERS  32  restoring-divider iteration count, one quotient bit per cycle
// PORTS
//  clk             in   1   single clock, posedge
//  resetn          in   1   asynchronous, active-low reset
//  ID_EX_valid     in   1   ID holds a valid instruction for EX
//  EX_allowin      out  1   EX accepts an instruction this cycle
//  ID_pc           in   32  instruction PC
//  ID_alu_op       in   12  one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
//  ID_md_op        in   7   one-hot {mul_w,mulh_w,mulh_wu,div_w,mod_w,div_wu,mod_wu}; 0 = use ALU
//  ID_alu_src1     in   32  operand 1
//  ID_alu_src2     in   32  operand 2
//  ID_rkd_value    in   32  store data
//  ID_res_from_mem in   1   load instruction
//  ID_mem_st_inst  in   3   {st_w,st_h,st_b}
//  ID_mem_ld_inst  in   5   {ld_w,ld_b,ld_h,ld_bu,ld_hu}
//  ID_rf_we        in   1   register-file write enable
//  ID_rf_waddr     in   5   destination register
//  MEM_allowin     in   1   MEM accepts next cycle
//  EX_MEM_valid    out  1   EX_valid & EX_ready_go
//  EX_pc           out  32  registered PC
//  EX_rf_bus       out  39  {res_from_mem, rf_we, rf_waddr, ex_result}
//  EX_mem_ld_inst  out  5   registered load type
//  EX_fwd_bus      out  39  {res_from_mem&EX_valid, rf_we&EX_valid, rf_waddr, ex_result}, for ID bypass/stall
//  data_sram_en    out  1   SRAM access strobe
//  data_sram_we    out  4   byte write enables
//  data_sram_addr  out  32  = ALU add result
//  data_sram_wdata out  32  replicated store data
// BEHAVIOUR
//  Reset (async) values:
//   - EX_valid=0, EX_pc=0, all payload registers 0, divider FSM=IDLE, counter=0.
//   - Hence EX_MEM_valid=0 and data_sram_en=0 immediately on reset assertion.
//  Handshake:
//   - EX_ready_go = ~is_div | (div_state==DONE).
//   - EX_allowin = ~EX_valid | (EX_ready_go & MEM_allowin).
//   - If EX_allowin: EX_valid <= ID_EX_valid.
//   - Payload registers load only on ID_EX_valid & EX_allowin; otherwise they hold.
//  ALU and multiply (combinational off the registered operands):
//   - slt is signed, sltu unsigned; shifts use src2[4:0].
//   - lui passes src2 through.
//   - mul_w returns the low 32 bits of the product; mulh_w / mulh_wu return the high 32 bits, signed / unsigned.
//  Divider FSM (states IDLE, BUSY, DONE):
//   - IDLE -> BUSY when EX_valid & is_div; latches |src1|, |src2| (signed ops) or the raw operands; cnt=0.
//   - BUSY: one restoring step per cycle. On cnt==DIV_ITERS-1 -> DONE.
//   - DONE: ready_go=1 and the result is held; -> IDLE on EX_ready_go & MEM_allowin.
//   - Latency: for DIV_ITERS=32 the div occupies EX for 34 cycles (IDLE, 32 BUSY, DONE) when MEM_allowin=1.
//   - Signed fixups: quotient negated if src1[31]^src2[31]; remainder takes the sign of src1.
//   - Divide by zero (defined): quotient=32'hFFFFFFFF (unsigned), remainder=dividend; signed ops apply the sign fixups above. No trap.
//   - 0x80000000 / -1 (signed): quotient=0x80000000, remainder=0.
//  Memory request (fired once, on the hand-off cycle):
//   - data_sram_en = EX_valid & EX_ready_go & MEM_allowin & (res_from_mem | |st_inst).
//   - data_sram_we, gated by that same condition:
//     - st_b: 4'b0001<<addr[1:0]
//     - st_h: 4'b0011<<{addr[1],1'b0}
//     - st_w: 4'hF
//     - load: 0
//   - data_sram_wdata: st_b {4{rkd[7:0]}}; st_h {2{rkd[15:0]}}; st_w rkd.
//   - Misaligned addresses are not checked; low bits are used as given.
//  Outputs:
//   - EX_rf_bus rf_we is ungated; MEM gates it with its own valid.
//   - ex_result = divider result if is_div, else multiplier result if mul op, else ALU result.
//  Boundary conditions:
//   - MEM_allowin=0 during DONE: the result and the DONE state hold; no SRAM request fires.
//   - Back-to-back divides: the second enters IDLE on the hand-off cycle and starts the next cycle.
//   - Reset mid-divide: FSM goes to IDLE asynchronously; the partial result is discarded.
// STRUCTURE
//  Shared package / defines file (cpu_defs):
//   - ALU_OP_* and MD_OP_* one-hot indices.
//   - EX_RF_BUS_W=39, EX_FWD_BUS_W=39.
//   - {st_w,st_h,st_b} and {ld_*} field orders.
//  Sub-module ex_divider:
//   - Iterative restoring divider: start, signed, op1, op2 -> quot, rem, done.
//   - Owns the IDLE/BUSY/DONE FSM and the counter.
// TESTING
//  1. add 5+7, MEM_allowin=1:
//     - EX_MEM_valid the cycle after capture; EX_rf_bus[31:0]=12; data_sram_en=0.
//  2. st_b, addr=0x1003, rkd=0xA5:
//     - data_sram_en=1, we=4'b1000, wdata=0xA5A5A5A5, for exactly one cycle.
//  3. div_w -7/2, then mod_w -7/2:
//     - Results 0xFFFFFFFD and 0xFFFFFFFF; EX_allowin=0 for 33 cycles after capture; each takes 34 cycles.
//  4. div_wu 10/0:
//     - Quotient 0xFFFFFFFF; mod_wu 10/0 -> 10; no hang.
//  5. div completes with MEM_allowin=0 for 3 cycles:
//     - DONE and the result hold; EX_MEM_valid=1 throughout; hand-off when MEM_allowin rises.
//  6. resetn asserted at BUSY cycle 10:
//     - EX_MEM_valid=0 and data_sram_en=0 immediately; a new div after reset starts cleanly.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_pkg
//   Shared definitions for the execute stage:
//   - one-hot bit indices of the ALU and multiply/divide opcode vectors
//   - field positions of the store/load type vectors
//   - EX->MEM / EX->ID bus widths
//   - divider FSM state encodings
//   - the registered EX payload struct
//   - small sign-fixup helper used by the divider
// ---------------------------------------------------------------------------
package ex_stage_pkg;

  // ALU one-hot: {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  localparam int ALU_OP_W = 12;
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // Multiply/divide one-hot: {mul_w,mulh_w,mulh_wu,div_w,mod_w,div_wu,mod_wu}
  localparam int MD_OP_W    = 7;
  localparam int MD_MUL_W   = 6;
  localparam int MD_MULH_W  = 5;
  localparam int MD_MULH_WU = 4;
  localparam int MD_DIV_W   = 3;
  localparam int MD_MOD_W   = 2;
  localparam int MD_DIV_WU  = 1;
  localparam int MD_MOD_WU  = 0;

  // Store type {st_w,st_h,st_b}
  localparam int ST_W_BIT = 2;
  localparam int ST_H_BIT = 1;
  localparam int ST_B_BIT = 0;

  // Load type {ld_w,ld_b,ld_h,ld_bu,ld_hu}
  localparam int LD_W_BIT  = 4;
  localparam int LD_B_BIT  = 3;
  localparam int LD_H_BIT  = 2;
  localparam int LD_BU_BIT = 1;
  localparam int LD_HU_BIT = 0;

  localparam int EX_RF_BUS_W  = 39;
  localparam int EX_FWD_BUS_W = 39;

  // Divider FSM encodings
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef struct packed {
    logic [31:0]         pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [MD_OP_W-1:0]  md_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         rkd;
    logic                res_from_mem;
    logic [2:0]          st_inst;
    logic [4:0]          ld_inst;
    logic                rf_we;
    logic [4:0]          rf_waddr;
  } ex_payload_t;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// ---------------------------------------------------------------------------
// ex_divider
//   Iterative restoring divider, one quotient bit per cycle.
//   Ports:
//     clk, resetn   clock, async active-low reset
//     start         begin a divide (sampled only in IDLE)
//     sign          signed operation (div_w / mod_w)
//     op1, op2      dividend, divisor (sampled on start)
//     ack           result consumed; DONE -> IDLE
//     quot, rem     sign-corrected quotient / remainder (valid in DONE)
//     done          FSM is in DONE
//     state         FSM state, exposed for observation
//   Divide by zero falls out of the restoring step naturally: every trial
//   subtraction succeeds, giving quotient all-ones and remainder = dividend.
// ---------------------------------------------------------------------------
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        ack,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done,
  output logic [1:0]  state
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      q_r;   // dividend shifting out / quotient shifting in
  logic [31:0]      r_r;   // partial remainder
  logic [31:0]      d_r;   // divisor magnitude
  logic             neg_q;
  logic             neg_r;
  logic [32:0]      r_shift;
  logic [32:0]      diff;

  // Bit 32 of diff set means the trial subtraction went negative (restore).
  always_comb begin
    r_shift = {r_r, q_r[31]};
    diff    = r_shift - {1'b0, d_r};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            q_r   <= neg_if(op1, sign & op1[31]);
            d_r   <= neg_if(op2, sign & op2[31]);
            r_r   <= '0;
            cnt   <= '0;
            neg_q <= sign & (op1[31] ^ op2[31]);
            neg_r <= sign & op1[31];
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (diff[32]) begin
            r_r <= r_shift[31:0];
            q_r <= {q_r[30:0], 1'b0};
          end else begin
            r_r <= diff[31:0];
            q_r <= {q_r[30:0], 1'b1};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // 0x80000000 / -1 needs no special case: |op1| = 0x80000000, quotient
  // magnitude 0x80000000, and its negation wraps back to 0x80000000.
  assign quot = neg_if(q_r, neg_q);
  assign rem  = neg_if(r_r, neg_r);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//   Execute stage of the 5-stage in-order LoongArch32 pipeline.
//   ALU, single-cycle multiply, iterative divide, data SRAM request issue and
//   the EX->MEM bundle.
//   Ports:
//     clk, resetn                 clock, async active-low reset
//     ID_EX_valid / EX_allowin    ID->EX handshake
//     ID_*                        decoded instruction payload from ID
//     MEM_allowin / EX_MEM_valid  EX->MEM handshake
//     EX_pc, EX_rf_bus,
//     EX_mem_ld_inst              EX->MEM bundle
//     EX_fwd_bus                  bypass/stall info back to ID
//     data_sram_*                 data SRAM request
//   Handshake: a stage transfers on a cycle where the sender's valid and the
//   receiver's allowin are both high at the clock edge; the sender holds its
//   payload until then. EX_allowin already folds in MEM_allowin, so EX only
//   advances when MEM can take the current instruction.
// ---------------------------------------------------------------------------
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ID_EX_valid,
  output logic                    EX_allowin,
  input  logic [31:0]             ID_pc,
  input  logic [ALU_OP_W-1:0]     ID_alu_op,
  input  logic [MD_OP_W-1:0]      ID_md_op,
  input  logic [31:0]             ID_alu_src1,
  input  logic [31:0]             ID_alu_src2,
  input  logic [31:0]             ID_rkd_value,
  input  logic                    ID_res_from_mem,
  input  logic [2:0]              ID_mem_st_inst,
  input  logic [4:0]              ID_mem_ld_inst,
  input  logic                    ID_rf_we,
  input  logic [4:0]              ID_rf_waddr,
  input  logic                    MEM_allowin,
  output logic                    EX_MEM_valid,
  output logic [31:0]             EX_pc,
  output logic [EX_RF_BUS_W-1:0]  EX_rf_bus,
  output logic [4:0]              EX_mem_ld_inst,
  output logic [EX_FWD_BUS_W-1:0] EX_fwd_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_we,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  ex_payload_t pl;
  ex_payload_t pl_d;
  logic        ex_valid;
  logic        ex_ready_go;

  assign pl_d = '{pc: ID_pc, alu_op: ID_alu_op, md_op: ID_md_op,
                  src1: ID_alu_src1, src2: ID_alu_src2, rkd: ID_rkd_value,
                  res_from_mem: ID_res_from_mem, st_inst: ID_mem_st_inst,
                  ld_inst: ID_mem_ld_inst, rf_we: ID_rf_we,
                  rf_waddr: ID_rf_waddr};

  assign EX_allowin   = ~ex_valid | (ex_ready_go & MEM_allowin);
  assign EX_MEM_valid = ex_valid & ex_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid <= 1'b0;
      pl       <= '0;
    end else begin
      if (EX_allowin) ex_valid <= ID_EX_valid;
      if (ID_EX_valid && EX_allowin) pl <= pl_d;
    end
  end

  // ---------------- ALU ----------------
  logic [31:0] add_res;
  logic [31:0] alu_res;
  logic [4:0]  shamt;

  assign add_res = pl.src1 + pl.src2;
  assign shamt   = pl.src2[4:0];

  // Opcode is one-hot, so the selected terms can simply be OR-ed together.
  always_comb begin
    alu_res = '0;
    if (pl.alu_op[ALU_ADD])  alu_res = alu_res | add_res;
    if (pl.alu_op[ALU_SUB])  alu_res = alu_res | (pl.src1 - pl.src2);
    if (pl.alu_op[ALU_SLT])  alu_res = alu_res | {31'd0, $signed(pl.src1) < $signed(pl.src2)};
    if (pl.alu_op[ALU_SLTU]) alu_res = alu_res | {31'd0, pl.src1 < pl.src2};
    if (pl.alu_op[ALU_AND])  alu_res = alu_res | (pl.src1 & pl.src2);
    if (pl.alu_op[ALU_NOR])  alu_res = alu_res | ~(pl.src1 | pl.src2);
    if (pl.alu_op[ALU_OR])   alu_res = alu_res | (pl.src1 | pl.src2);
    if (pl.alu_op[ALU_XOR])  alu_res = alu_res | (pl.src1 ^ pl.src2);
    if (pl.alu_op[ALU_SLL])  alu_res = alu_res | (pl.src1 << shamt);
    if (pl.alu_op[ALU_SRL])  alu_res = alu_res | (pl.src1 >> shamt);
    if (pl.alu_op[ALU_SRA])  alu_res = alu_res | $unsigned($signed(pl.src1) >>> shamt);
    if (pl.alu_op[ALU_LUI])  alu_res = alu_res | pl.src2;
  end

  // ---------------- multiply ----------------
  // Sign-extending to 64 bits makes one unsigned multiplier serve both
  // mulh_w and mulh_wu; the low word is identical for either signedness.
  logic        is_mul;
  logic        mul_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] mul_res;

  assign is_mul  = pl.md_op[MD_MUL_W] | pl.md_op[MD_MULH_W] | pl.md_op[MD_MULH_WU];
  assign mul_sgn = pl.md_op[MD_MULH_W];
  assign mul_a   = {{32{mul_sgn & pl.src1[31]}}, pl.src1};
  assign mul_b   = {{32{mul_sgn & pl.src2[31]}}, pl.src2};
  assign prod    = mul_a * mul_b;
  assign mul_res = pl.md_op[MD_MUL_W] ? prod[31:0] : prod[63:32];

  // ---------------- divide ----------------
  logic        is_div;
  logic        is_mod;
  logic        div_sgn;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_done;
  logic [1:0]  div_state;

  assign is_div  = pl.md_op[MD_DIV_W] | pl.md_op[MD_MOD_W] |
                   pl.md_op[MD_DIV_WU] | pl.md_op[MD_MOD_WU];
  assign is_mod  = pl.md_op[MD_MOD_W] | pl.md_op[MD_MOD_WU];
  assign div_sgn = pl.md_op[MD_DIV_W] | pl.md_op[MD_MOD_W];

  ex_divider #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (ex_valid & is_div),
    .sign   (div_sgn),
    .op1    (pl.src1),
    .op2    (pl.src2),
    .ack    (ex_ready_go & MEM_allowin),
    .quot   (div_quot),
    .rem    (div_rem),
    .done   (div_done),
    .state  (div_state)
  );

  assign ex_ready_go = ~is_div | div_done;

  logic [31:0] ex_result;
  assign ex_result = is_div ? (is_mod ? div_rem : div_quot) :
                     is_mul ? mul_res : alu_res;

  // ---------------- data SRAM request ----------------
  // Fires only on the hand-off cycle so a stalled or dividing instruction
  // never issues a duplicate access.
  logic       mem_fire;
  logic [3:0] st_we;

  assign mem_fire = ex_valid & ex_ready_go & MEM_allowin &
                    (pl.res_from_mem | (|pl.st_inst));

  always_comb begin
    st_we = 4'h0;
    if (pl.st_inst[ST_W_BIT])      st_we = 4'hF;
    else if (pl.st_inst[ST_H_BIT]) st_we = 4'b0011 << {add_res[1], 1'b0};
    else if (pl.st_inst[ST_B_BIT]) st_we = 4'b0001 << add_res[1:0];
  end

  assign data_sram_en    = mem_fire;
  assign data_sram_we    = mem_fire ? st_we : 4'h0;
  assign data_sram_addr  = add_res;
  assign data_sram_wdata = pl.st_inst[ST_B_BIT] ? {4{pl.rkd[7:0]}}  :
                           pl.st_inst[ST_H_BIT] ? {2{pl.rkd[15:0]}} : pl.rkd;

  // ---------------- outputs ----------------
  assign EX_pc          = pl.pc;
  assign EX_mem_ld_inst = pl.ld_inst;
  assign EX_rf_bus      = {pl.res_from_mem, pl.rf_we, pl.rf_waddr, ex_result};
  assign EX_fwd_bus     = {pl.res_from_mem & ex_valid, pl.rf_we & ex_valid,
                           pl.rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
//   Table of ALU / multiply / divide vectors with hand-derived results, plus
//   directed sequences for store strobes, divide timing, MEM back-pressure
//   and reset mid-divide. Results leaving EX are matched against a queue of
//   expected values filled when each instruction is issued.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        ID_EX_valid;
  logic        EX_allowin;
  logic [31:0] ID_pc;
  logic [11:0] ID_alu_op;
  logic [6:0]  ID_md_op;
  logic [31:0] ID_alu_src1;
  logic [31:0] ID_alu_src2;
  logic [31:0] ID_rkd_value;
  logic        ID_res_from_mem;
  logic [2:0]  ID_mem_st_inst;
  logic [4:0]  ID_mem_ld_inst;
  logic        ID_rf_we;
  logic [4:0]  ID_rf_waddr;
  logic        MEM_allowin;
  logic        EX_MEM_valid;
  logic [31:0] EX_pc;
  logic [38:0] EX_rf_bus;
  logic [4:0]  EX_mem_ld_inst;
  logic [38:0] EX_fwd_bus;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  ex_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ID_EX_valid     (ID_EX_valid),
    .EX_allowin      (EX_allowin),
    .ID_pc           (ID_pc),
    .ID_alu_op       (ID_alu_op),
    .ID_md_op        (ID_md_op),
    .ID_alu_src1     (ID_alu_src1),
    .ID_alu_src2     (ID_alu_src2),
    .ID_rkd_value    (ID_rkd_value),
    .ID_res_from_mem (ID_res_from_mem),
    .ID_mem_st_inst  (ID_mem_st_inst),
    .ID_mem_ld_inst  (ID_mem_ld_inst),
    .ID_rf_we        (ID_rf_we),
    .ID_rf_waddr     (ID_rf_waddr),
    .MEM_allowin     (MEM_allowin),
    .EX_MEM_valid    (EX_MEM_valid),
    .EX_pc           (EX_pc),
    .EX_rf_bus       (EX_rf_bus),
    .EX_mem_ld_inst  (EX_mem_ld_inst),
    .EX_fwd_bus      (EX_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  // ---------------- opcode encodings ----------------
  localparam logic [11:0] A_ADD  = 12'h800, A_SUB = 12'h400, A_SLT = 12'h200,
                          A_SLTU = 12'h100, A_AND = 12'h080, A_NOR = 12'h040,
                          A_OR   = 12'h020, A_XOR = 12'h010, A_SLL = 12'h008,
                          A_SRL  = 12'h004, A_SRA = 12'h002, A_LUI = 12'h001;
  localparam logic [6:0]  M_MUL = 7'h40, M_MULH = 7'h20, M_MULHU = 7'h10,
                          M_DIV = 7'h08, M_MOD  = 7'h04, M_DIVU  = 7'h02,
                          M_MODU = 7'h01;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int last_cap = 0;
  int pc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every hand-off to MEM retires the oldest expected result.
  always @(negedge clk) begin
    if (resetn && EX_MEM_valid && MEM_allowin) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %h expected no hand-off", EX_rf_bus[31:0]);
      end else begin
        check("sb_result", EX_rf_bus[31:0], exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Callable at a negedge or just after a posedge. Returns #1 after the
  // capture edge with ID_EX_valid dropped.
  task automatic issue(input logic [11:0] aop, input logic [6:0] mop,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] st, input logic [4:0] ld,
                       input logic [31:0] rkd, input logic [31:0] exp);
    int n;
    ID_EX_valid     = 1'b1;
    ID_pc           = 32'h1c00_0000 + 32'(pc_n * 4);
    ID_alu_op       = aop;
    ID_md_op        = mop;
    ID_alu_src1     = a;
    ID_alu_src2     = b;
    ID_rkd_value    = rkd;
    ID_mem_st_inst  = st;
    ID_mem_ld_inst  = ld;
    ID_res_from_mem = |ld;
    ID_rf_we        = ~|st;
    ID_rf_waddr     = 5'd4;
    pc_n++;
    exp_q.push_back(exp);
    #1;
    n = 0;
    while (!EX_allowin && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!EX_allowin) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got allowin=0 expected allowin=1");
    end
    @(posedge clk);
    #1;
    last_cap    = cyc;
    ID_EX_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (EX_allowin) break;
      n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [11:0] aop;
    logic [6:0]  mop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input string nm, input logic [11:0] aop,
                                  input logic [6:0] mop, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name = nm; v.aop = aop; v.mop = mop; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // ---------------- main ----------------
  initial begin
    int n;
    int cap1;
    logic [31:0] r;

    add_vec("add",       A_ADD,  7'h0,    32'd5,        32'd7,        32'h0000_000C);
    add_vec("sub",       A_SUB,  7'h0,    32'd3,        32'd5,        32'hFFFF_FFFE);
    add_vec("slt",       A_SLT,  7'h0,    32'hFFFF_FFFF, 32'd1,       32'd1);
    add_vec("sltu",      A_SLTU, 7'h0,    32'hFFFF_FFFF, 32'd1,       32'd0);
    add_vec("and",       A_AND,  7'h0,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    add_vec("nor",       A_NOR,  7'h0,    32'h0F0F_0000, 32'h0000_F0F0, 32'hF0F0_0F0F);
    add_vec("or",        A_OR,   7'h0,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    add_vec("xor",       A_XOR,  7'h0,    32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    add_vec("sll",       A_SLL,  7'h0,    32'd1,        32'h0000_0023, 32'd8);
    add_vec("srl",       A_SRL,  7'h0,    32'h8000_0000, 32'd31,      32'd1);
    add_vec("sra",       A_SRA,  7'h0,    32'h8000_0000, 32'd4,       32'hF800_0000);
    add_vec("lui",       A_LUI,  7'h0,    32'd0,        32'hABCD_E000, 32'hABCD_E000);
    add_vec("mul_w",     12'h0,  M_MUL,   32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE);
    add_vec("mulh_w",    12'h0,  M_MULH,  32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF);
    add_vec("mulh_wu",   12'h0,  M_MULHU, 32'hFFFF_FFFF, 32'd2,       32'h0000_0001);
    add_vec("mulh_w_mm", 12'h0,  M_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    add_vec("div_wu_z",  12'h0,  M_DIVU,  32'd10,       32'd0,        32'hFFFF_FFFF);
    add_vec("mod_wu_z",  12'h0,  M_MODU,  32'd10,       32'd0,        32'd10);
    add_vec("div_w_ovf", 12'h0,  M_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    add_vec("mod_w_ovf", 12'h0,  M_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    add_vec("div_wu",    12'h0,  M_DIVU,  32'd100,      32'd7,        32'd14);
    add_vec("mod_wu",    12'h0,  M_MODU,  32'd100,      32'd7,        32'd2);
    add_vec("div_w_nz",  12'h0,  M_DIV,   32'hFFFF_FFF9, 32'd0,       32'd1);
    add_vec("mod_w_nz",  12'h0,  M_MOD,   32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9);

    // Reset state
    resetn = 1'b0; ID_EX_valid = 1'b0; MEM_allowin = 1'b1;
    ID_pc = '0; ID_alu_op = '0; ID_md_op = '0; ID_alu_src1 = '0; ID_alu_src2 = '0;
    ID_rkd_value = '0; ID_res_from_mem = 1'b0; ID_mem_st_inst = '0;
    ID_mem_ld_inst = '0; ID_rf_we = 1'b0; ID_rf_waddr = '0;
    repeat (3) @(negedge clk);
    check("rst_ex_mem_valid", 32'(EX_MEM_valid), 32'd0);
    check("rst_allowin",      32'(EX_allowin),   32'd1);
    check("rst_sram_en",      32'(data_sram_en), 32'd0);
    check("rst_pc",           EX_pc,             32'd0);
    check("rst_rf_bus",       EX_rf_bus[31:0],   32'd0);
    check("rst_fwd_hi",       32'(EX_fwd_bus[38:32]), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // add 5+7: hand-off the cycle after capture, no SRAM access
    issue(A_ADD, 7'h0, 32'd5, 32'd7, 3'b000, 5'b0, 32'd0, 32'd12);
    check("add_ex_mem_valid", 32'(EX_MEM_valid), 32'd1);
    check("add_result",       EX_rf_bus[31:0],   32'd12);
    check("add_sram_en",      32'(data_sram_en), 32'd0);
    check("add_pc",           EX_pc,             32'h1c00_0000);
    check("add_rf_we_waddr",  32'(EX_rf_bus[37:32]), 32'h24);
    check("add_fwd_flags",    32'(EX_fwd_bus[38:37]), 32'd1);
    drain();

    // Table-driven ALU / mul / div vectors
    foreach (vecs[i]) begin
      issue(vecs[i].aop, vecs[i].mop, vecs[i].a, vecs[i].b, 3'b000, 5'b0, 32'd0, vecs[i].exp);
      if (vecs[i].mop == 7'h0) check({"tbl_", vecs[i].name}, EX_rf_bus[31:0], vecs[i].exp);
      drain();
    end

    // Stores and load: one-cycle strobes with lane enables
    issue(A_ADD, 7'h0, 32'h1000, 32'd3, 3'b001, 5'b0, 32'h0000_00A5, 32'h1003);
    check("stb_en",    32'(data_sram_en), 32'd1);
    check("stb_we",    32'(data_sram_we), 32'h8);
    check("stb_wdata", data_sram_wdata,   32'hA5A5_A5A5);
    check("stb_addr",  data_sram_addr,    32'h1003);
    @(posedge clk); #1;
    check("stb_en_once", 32'(data_sram_en), 32'd0);
    drain();
    issue(A_ADD, 7'h0, 32'h1000, 32'd2, 3'b010, 5'b0, 32'h1234_BEEF, 32'h1002);
    check("sth_we",    32'(data_sram_we), 32'hC);
    check("sth_wdata", data_sram_wdata,   32'hBEEF_BEEF);
    drain();
    issue(A_ADD, 7'h0, 32'h1000, 32'd0, 3'b100, 5'b0, 32'hDEAD_BEEF, 32'h1000);
    check("stw_we",    32'(data_sram_we), 32'hF);
    check("stw_wdata", data_sram_wdata,   32'hDEAD_BEEF);
    drain();
    issue(A_ADD, 7'h0, 32'h2000, 32'd4, 3'b000, 5'b10000, 32'd0, 32'h2004);
    check("ldw_en",     32'(data_sram_en),   32'd1);
    check("ldw_we",     32'(data_sram_we),   32'd0);
    check("ldw_resmem", 32'(EX_rf_bus[38]),  32'd1);
    check("ldw_ldinst", 32'(EX_mem_ld_inst), 32'h10);
    drain();

    // div_w -7/2 then mod_w -7/2 back to back
    issue(12'h0, M_DIV, 32'hFFFF_FFF9, 32'd2, 3'b000, 5'b0, 32'd0, 32'hFFFF_FFFD);
    cap1 = last_cap;
    count_stall(n);
    check("div_stall_cycles", 32'(n), 32'd33);
    issue(12'h0, M_MOD, 32'hFFFF_FFF9, 32'd2, 3'b000, 5'b0, 32'd0, 32'hFFFF_FFFF);
    check("div_occupancy", 32'(last_cap - cap1), 32'd34);
    count_stall(n);
    check("mod_stall_cycles", 32'(n), 32'd33);
    drain();

    // Divide finishing under MEM back-pressure
    issue(12'h0, M_DIVU, 32'd100, 32'd7, 3'b000, 5'b0, 32'd0, 32'd14);
    MEM_allowin = 1'b0;
    n = 0;
    while (!EX_MEM_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_ex_mem_valid", 32'(EX_MEM_valid), 32'd1);
      check("bp_result",       EX_rf_bus[31:0],   32'd14);
      check("bp_allowin",      32'(EX_allowin),   32'd0);
    end
    @(posedge clk); #1;
    MEM_allowin = 1'b1;
    drain();
    check("bp_after_valid", 32'(EX_MEM_valid), 32'd0);

    // Reset asserted in BUSY cycle 10, then a clean divide
    issue(12'h0, M_DIV, 32'd1000, 32'd3, 3'b000, 5'b0, 32'd0, 32'd333);
    repeat (10) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_mid_valid",   32'(EX_MEM_valid), 32'd0);
    check("rst_mid_sram_en", 32'(data_sram_en), 32'd0);
    check("rst_mid_allowin", 32'(EX_allowin),   32'd1);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue(12'h0, M_DIV, 32'd7, 32'hFFFF_FFFE, 3'b000, 5'b0, 32'd0, 32'hFFFF_FFFD);
    cap1 = last_cap;
    count_stall(n);
    check("post_rst_stall", 32'(n), 32'd33);
    issue(12'h0, M_MOD, 32'd7, 32'hFFFF_FFFE, 3'b000, 5'b0, 32'd0, 32'd1);
    drain();
    r = EX_rf_bus[31:0];
    check("post_rst_hold", r, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
